fetch_unit: RTL and testbench

// Instruction sequencer directly upstream of control_unit: owns the PC, drives the instruction ROM, latches
// the 15-bit word into an instruction register and presents {opcode, k8} to control_unit and the datapath.

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/fetch_unit_branch_cond.sv | 31 +++
 rtl/fetch_unit.sv | 133 +++++++++++++
 tb/tb_fetch_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer: FSM states, control-flow opcodes,
// and instruction word field positions.
package fetch_pkg;

   typedef enum logic [1:0] {
      StFetch = 2'd0,
      StExec  = 2'd1,
      StHalt  = 2'd2
   } state_e;

   localparam int unsigned OPC_MSB = 14;
   localparam int unsigned OPC_LSB = 8;
   localparam int unsigned LIT_MSB = 7;

   localparam logic [6:0] OP_JMP  = 7'h50;
   localparam logic [6:0] OP_JEQ  = 7'h51;
   localparam logic [6:0] OP_JNE  = 7'h52;
   localparam logic [6:0] OP_JGT  = 7'h53;
   localparam logic [6:0] OP_JLT  = 7'h54;
   localparam logic [6:0] OP_JGE  = 7'h55;
   localparam logic [6:0] OP_JLE  = 7'h56;
   localparam logic [6:0] OP_JCR  = 7'h57;
   localparam logic [6:0] OP_JOV  = 7'h58;
   localparam logic [6:0] OP_CALL = 7'h59;
   localparam logic [6:0] OP_RET  = 7'h5A;
   localparam logic [6:0] OP_HALT = 7'h7F;

endpackage

// File: rtl/fetch_unit_branch_cond.sv
// Jump decode: flags {Z,N,C,V} and opcode -> whether this is a jump and whether it is taken.
module fetch_unit_branch_cond
   import fetch_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [3:0] flags_status,
   output logic       is_jump,
   output logic       taken
);

   logic z, n, c, v;
   assign {z, n, c, v} = flags_status;

   always_comb begin
      is_jump = 1'b1;
      taken   = 1'b0;
      case (opcode)
         OP_JMP:  taken = 1'b1;
         OP_JEQ:  taken = z;
         OP_JNE:  taken = ~z;
         OP_JGT:  taken = ~n & ~z;
         OP_JLT:  taken = n;
         OP_JGE:  taken = ~n;
         OP_JLE:  taken = n | z;
         OP_JCR:  taken = c;
         OP_JOV:  taken = v;
         default: is_jump = 1'b0;
      endcase
   end

endmodule

// File: rtl/fetch_unit.sv
// Two-cycle FETCH/EXEC instruction sequencer owning PC and IR; resolves jumps and HALT.
// Optional return-address stack for CALL/RET enabled by defining CALL_STACK_EN.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned PC_W        = 8,
   parameter int unsigned STACK_DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            run,
   output logic [PC_W-1:0] im_addr,
   input  logic [14:0]     im_data,
   input  logic [3:0]      flags_status,
   output logic [6:0]      opcode,
   output logic [7:0]      k8,
   output logic            exec_valid,
   output logic [PC_W-1:0] pc,
   output logic            halted,
   output logic            stack_err
);

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [14:0]     ir_q, ir_d;
   logic            is_jump, taken;
   logic [PC_W-1:0] pc_inc, target;

   assign opcode     = ir_q[OPC_MSB:OPC_LSB];
   assign k8         = ir_q[LIT_MSB:0];
   assign im_addr    = pc_q;
   assign pc         = pc_q;
   assign exec_valid = (state_q == StExec);
   assign halted     = (state_q == StHalt);
   assign pc_inc     = pc_q + PC_W'(1);
   assign target     = PC_W'(k8);

   fetch_unit_branch_cond u_branch_cond (
      .opcode       (opcode),
      .flags_status (flags_status),
      .is_jump      (is_jump),
      .taken        (taken)
   );

`ifdef CALL_STACK_EN
   localparam int unsigned SP_W = $clog2(STACK_DEPTH + 1);
   logic [SP_W-1:0] sp_q, sp_d;
   logic [PC_W-1:0] stack_q [STACK_DEPTH];
   logic [PC_W-1:0] stack_d [STACK_DEPTH];
   logic            err_q, err_d;
   assign stack_err = err_q;
`else
   assign stack_err = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
`ifdef CALL_STACK_EN
      sp_d    = sp_q;
      stack_d = stack_q;
      err_d   = err_q;
`endif
      if (run) begin
         case (state_q)
            StFetch: begin
               ir_d    = im_data;
               state_d = StExec;
            end
            StExec: begin
               state_d = StFetch;
               pc_d    = (is_jump && taken) ? target : pc_inc;
               if (opcode == OP_HALT) begin
                  state_d = StHalt;
                  pc_d    = pc_q;
               end
`ifdef CALL_STACK_EN
               if (opcode == OP_CALL) begin
                  if (sp_q == SP_W'(STACK_DEPTH)) begin
                     err_d   = 1'b1;
                     state_d = StHalt;
                     pc_d    = pc_q;
                  end else begin
                     for (int i = 0; i < STACK_DEPTH; i++) begin
                        if (sp_q == SP_W'(i)) stack_d[i] = pc_inc;
                     end
                     sp_d = sp_q + SP_W'(1);
                     pc_d = target;
                  end
               end
               if (opcode == OP_RET) begin
                  if (sp_q == '0) begin
                     err_d   = 1'b1;
                     state_d = StHalt;
                     pc_d    = pc_q;
                  end else begin
                     for (int i = 0; i < STACK_DEPTH; i++) begin
                        if (sp_q == SP_W'(i + 1)) pc_d = stack_q[i];
                     end
                     sp_d = sp_q - SP_W'(1);
                  end
               end
`endif
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StFetch;
         pc_q    <= '0;
         ir_q    <= '0;
`ifdef CALL_STACK_EN
         sp_q    <= '0;
         err_q   <= 1'b0;
         for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
`ifdef CALL_STACK_EN
         sp_q    <= sp_d;
         err_q   <= err_d;
         stack_q <= stack_d;
`endif
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table through a small ROM plus multi-cycle sequences.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        run = 1'b1;
   logic [7:0]  im_addr;
   logic [14:0] im_data;
   logic [3:0]  flags_status = 4'h0;
   logic [6:0]  opcode;
   logic [7:0]  k8;
   logic        exec_valid;
   logic [7:0]  pc;
   logic        halted;
   logic        stack_err;

   logic [14:0] rom [256];
   int          total = 0;
   int          bad = 0;

   typedef struct {
      logic [14:0] instr;
      logic [3:0]  flags;
      logic [7:0]  at;
      logic [7:0]  exp_pc;
      logic        exp_halt;
   } vec_t;

   typedef struct {
      logic [7:0] pc;
      logic       halted;
      logic       err;
   } exp_t;

   vec_t vecs [14];
   exp_t sb [$];

   fetch_unit #(.PC_W(8), .STACK_DEPTH(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .run          (run),
      .im_addr      (im_addr),
      .im_data      (im_data),
      .flags_status (flags_status),
      .opcode       (opcode),
      .k8           (k8),
      .exec_valid   (exec_valid),
      .pc           (pc),
      .halted       (halted),
      .stack_err    (stack_err)
   );

   always #5 clk = ~clk;
   assign im_data = rom[im_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = 15'h0000;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{{7'h51, 8'h20}, 4'b1000, 8'h03, 8'h20, 1'b0}; // JEQ Z=1
      vecs[1]  = '{{7'h51, 8'h20}, 4'b0000, 8'h03, 8'h04, 1'b0}; // JEQ Z=0
      vecs[2]  = '{{7'h56, 8'h20}, 4'b0000, 8'h03, 8'h04, 1'b0}; // JLE N=0 Z=0
      vecs[3]  = '{{7'h56, 8'h20}, 4'b0100, 8'h03, 8'h20, 1'b0}; // JLE N=1
      vecs[4]  = '{{7'h52, 8'h30}, 4'b0000, 8'h05, 8'h30, 1'b0}; // JNE Z=0
      vecs[5]  = '{{7'h53, 8'h30}, 4'b1000, 8'h05, 8'h06, 1'b0}; // JGT Z=1
      vecs[6]  = '{{7'h54, 8'h30}, 4'b0100, 8'h05, 8'h30, 1'b0}; // JLT N=1
      vecs[7]  = '{{7'h55, 8'h30}, 4'b0100, 8'h05, 8'h06, 1'b0}; // JGE N=1
      vecs[8]  = '{{7'h57, 8'h44}, 4'b0010, 8'h09, 8'h44, 1'b0}; // JCR C=1
      vecs[9]  = '{{7'h58, 8'h44}, 4'b1110, 8'h09, 8'h0a, 1'b0}; // JOV V=0
      vecs[10] = '{{7'h04, 8'h00}, 4'b0000, 8'hff, 8'h00, 1'b0}; // ADD at FF wraps
      vecs[11] = '{{7'h50, 8'h12}, 4'b0000, 8'h20, 8'h12, 1'b0}; // JMP
      vecs[12] = '{{7'h7f, 8'h00}, 4'b0000, 8'h07, 8'h07, 1'b1}; // HALT
`ifdef CALL_STACK_EN
      vecs[13] = '{{7'h59, 8'h40}, 4'b0000, 8'h10, 8'h40, 1'b0}; // CALL
`else
      vecs[13] = '{{7'h59, 8'h40}, 4'b0000, 8'h10, 8'h11, 1'b0}; // CALL as NOP
`endif

      // Reset state and first two instructions
      clear_rom();
      rom[0] = {7'h04, 8'h00};
      rom[1] = {7'h02, 8'h05};
      do_reset();
      check("rst_pc", 32'(pc), 32'h0);
      check("rst_opcode", 32'(opcode), 32'h0);
      check("rst_k8", 32'(k8), 32'h0);
      check("rst_ev", 32'(exec_valid), 32'h0);
      check("rst_halted", 32'(halted), 32'h0);
      check("rst_err", 32'(stack_err), 32'h0);
      check("seq_addr0", 32'(im_addr), 32'h0);
      tick();
      check("seq_addr1", 32'(im_addr), 32'h0);
      check("seq_ev1", 32'(exec_valid), 32'h1);
      check("seq_op1", 32'(opcode), 32'h04);
      tick();
      check("seq_addr2", 32'(im_addr), 32'h1);
      check("seq_ev2", 32'(exec_valid), 32'h0);
      tick();
      check("seq_ev3", 32'(exec_valid), 32'h1);
      check("seq_op3", 32'(opcode), 32'h02);
      check("seq_k8_3", 32'(k8), 32'h05);
      tick();
      check("seq_addr4", 32'(im_addr), 32'h2);

      // Table: JMP to vector address, then execute the vector's instruction
      for (int v = 0; v < 14; v++) begin
         exp_t e;
         clear_rom();
         rom[0] = {7'h50, vecs[v].at};
         rom[vecs[v].at] = vecs[v].instr;
         flags_status = vecs[v].flags;
         sb.push_back('{vecs[v].exp_pc, vecs[v].exp_halt, 1'b0});
         do_reset();
         repeat (4) tick();
         e = sb.pop_front();
         check($sformatf("vec%0d_pc", v), 32'(pc), 32'(e.pc));
         check($sformatf("vec%0d_halt", v), 32'(halted), 32'(e.halted));
         check($sformatf("vec%0d_err", v), 32'(stack_err), 32'(e.err));
      end
      flags_status = 4'h0;

      // HALT persists until reset
      clear_rom();
      rom[0] = {7'h50, 8'h07};
      rom[7] = {7'h7f, 8'h00};
      do_reset();
      repeat (4) tick();
      for (int i = 0; i < 10; i++) begin
         tick();
         check("halt_ev", 32'(exec_valid), 32'h0);
         check("halt_pc", 32'(pc), 32'h07);
         check("halt_flag", 32'(halted), 32'h1);
      end
      do_reset();
      check("halt_rst_pc", 32'(pc), 32'h0);
      check("halt_rst_halted", 32'(halted), 32'h0);
      check("halt_rst_ev", 32'(exec_valid), 32'h0);

      // run=0 freeze mid-EXEC, resume, then reset mid-EXEC
      clear_rom();
      rom[0] = {7'h04, 8'h11};
      rom[1] = {7'h02, 8'h22};
      do_reset();
      tick();
      run = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("frz_pc", 32'(pc), 32'h0);
         check("frz_ev", 32'(exec_valid), 32'h1);
         check("frz_ir", 32'({opcode, k8}), 32'h0411);
      end
      run = 1'b1;
      tick();
      check("resume_pc", 32'(pc), 32'h1);
      check("resume_ev", 32'(exec_valid), 32'h0);
      tick();
      check("resume_ir", 32'({opcode, k8}), 32'h0222);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_pc", 32'(pc), 32'h0);
      check("midrst_ev", 32'(exec_valid), 32'h0);

`ifdef CALL_STACK_EN
      // CALL then RET returns to the following instruction
      clear_rom();
      rom[8'h00] = {7'h50, 8'h10};
      rom[8'h10] = {7'h59, 8'h40};
      rom[8'h40] = {7'h5a, 8'h00};
      do_reset();
      repeat (4) tick();
      check("call_pc", 32'(pc), 32'h40);
      repeat (2) tick();
      check("ret_pc", 32'(pc), 32'h11);
      check("ret_err", 32'(stack_err), 32'h0);

      // Fifth nested CALL overflows a 4-deep stack
      clear_rom();
      for (int k = 0; k < 5; k++) rom[k] = {7'h59, 8'(k + 1)};
      do_reset();
      repeat (12) tick();
      check("ovf_err", 32'(stack_err), 32'h1);
      check("ovf_halt", 32'(halted), 32'h1);
      check("ovf_pc", 32'(pc), 32'h04);

      // RET on empty stack
      clear_rom();
      rom[0] = {7'h5a, 8'h00};
      do_reset();
      repeat (2) tick();
      check("unf_err", 32'(stack_err), 32'h1);
      check("unf_halt", 32'(halted), 32'h1);
      check("unf_pc", 32'(pc), 32'h00);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
